// File: rtl/bus_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bus_pkg : state encoding, bus sizing and beat-count helper for bus targets
// Rev 1.0
// ----------------------------------------------------------------------------
package bus_pkg;

  localparam int DATA_W    = 32;
  localparam int LINE_W    = 128;
  localparam int ADDR_W    = 16;
  localparam int MAX_BEATS = LINE_W / DATA_W;
  localparam int BEAT_W    = $clog2(MAX_BEATS);

  localparam logic [2:0] BUS_IDLE_DEST = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR_ACK   = 3'd1,
    ST_WDATA     = 3'd2,
    ST_MOD_WRITE = 3'd3,
    ST_WDONE     = 3'd4,
    ST_MOD_READ  = 3'd5,
    ST_RDATA     = 3'd6
  } state_t;

  // ceil(size/4), saturating at one full line; a zero size is rejected before use.
  function automatic logic [2:0] beats_from_size(input logic [11:0] size);
    logic [4:0] rounded;
    rounded = size[4:0] + 5'd3;
    if (size > 12'd16) return 3'(MAX_BEATS);
    return rounded[4:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// line_packer : inserts a bus beat into a line lane / selects a line lane
// Rev 1.0
// ----------------------------------------------------------------------------
module line_packer
  import bus_pkg::*;
(
  input  logic [BEAT_W-1:0] beat,
  input  logic [DATA_W-1:0] lane_in,
  input  logic [LINE_W-1:0] line_in,
  input  logic [LINE_W-1:0] rd_line,
  output logic [LINE_W-1:0] line_out,
  output logic [DATA_W-1:0] lane_out
);

  always_comb begin
    line_out                        = line_in;
    line_out[beat*DATA_W +: DATA_W] = lane_in;
    lane_out                        = rd_line[beat*DATA_W +: DATA_W];
  end

endmodule
`default_nettype wire

// File: rtl/bus_slave_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bus_slave_responder : bus target; bridges header-addressed transfers to one
// 128-bit line access on the local module port.                     Rev 1.0
// ----------------------------------------------------------------------------
module bus_slave_responder
  import bus_pkg::*;
(
  input  logic              BUS_CLK,
  input  logic              RST,
  input  logic [2:0]        MY_ID,
  input  logic [ADDR_W-1:0] A,
  input  logic [2:0]        MASTER,
  input  logic [2:0]        DEST,
  input  logic [11:0]       SIZE,
  input  logic              RW,
  inout  wire  [DATA_W-1:0] D,
  inout  wire               ACK,
  output logic              MOD_EN,
  output logic              MOD_WR,
  output logic [ADDR_W-1:0] MOD_A,
  output logic [LINE_W-1:0] MOD_WRITE_DATA,
  input  logic [LINE_W-1:0] MOD_READ_DATA,
  input  logic              MOD_R,
  output logic              BUSY
);

  state_t            state, state_nx;
  logic [BEAT_W-1:0] beat, last_beat;
  logic              is_write;
  logic [2:0]        owner_master;
  logic [LINE_W-1:0] wr_line, rd_line, packed_line;
  logic [DATA_W-1:0] rd_lane;
  logic [2:0]        hdr_beats;
  logic              hdr_hit, last_beat_hit, ack_val, d_oe;
  logic              unused_owner;

  assign hdr_hit       = (DEST == MY_ID) && (DEST != BUS_IDLE_DEST) && (SIZE != 12'd0);
  assign hdr_beats     = beats_from_size(SIZE);
  assign last_beat_hit = (beat == last_beat);
  // Owning master is held for bus-side visibility only; the datapath ignores it.
  assign unused_owner  = ^owner_master;

  line_packer u_line_packer (
    .beat     (beat),
    .lane_in  (D),
    .line_in  (wr_line),
    .rd_line  (rd_line),
    .line_out (packed_line),
    .lane_out (rd_lane)
  );

  always_ff @(posedge BUS_CLK or negedge RST) begin
    if (!RST) begin
      state        <= ST_IDLE;
      beat         <= '0;
      last_beat    <= '0;
      is_write     <= 1'b0;
      owner_master <= '0;
      MOD_A        <= '0;
      wr_line      <= '0;
      rd_line      <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (hdr_hit) begin
            MOD_A        <= A;
            is_write     <= RW;
            owner_master <= MASTER;
            last_beat    <= BEAT_W'(hdr_beats - 3'd1);
            beat         <= '0;
            wr_line      <= '0;
          end
        end
        ST_WDATA: begin
          wr_line <= packed_line;
          if (!last_beat_hit) beat <= beat + BEAT_W'(1);
        end
        ST_MOD_READ: begin
          if (MOD_R) rd_line <= MOD_READ_DATA;
        end
        ST_RDATA: begin
          if (!last_beat_hit) beat <= beat + BEAT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    MOD_EN   = 1'b0;
    MOD_WR   = 1'b0;
    ack_val  = 1'b0;
    d_oe     = 1'b0;
    case (state)
      ST_IDLE:      if (hdr_hit) state_nx = ST_HDR_ACK;
      ST_HDR_ACK: begin
        ack_val  = 1'b1;
        state_nx = is_write ? ST_WDATA : ST_MOD_READ;
      end
      ST_WDATA:     if (last_beat_hit) state_nx = ST_MOD_WRITE;
      ST_MOD_WRITE: begin
        MOD_EN = 1'b1;
        MOD_WR = 1'b1;
        if (MOD_R) state_nx = ST_WDONE;
      end
      ST_WDONE: begin
        ack_val  = 1'b1;
        state_nx = ST_IDLE;
      end
      ST_MOD_READ: begin
        MOD_EN = 1'b1;
        if (MOD_R) state_nx = ST_RDATA;
      end
      ST_RDATA: begin
        ack_val = 1'b1;
        d_oe    = 1'b1;
        if (last_beat_hit) state_nx = ST_IDLE;
      end
      default:      state_nx = ST_IDLE;
    endcase
  end

  // ACK is owned for the whole transfer, so any non-idle state drives it.
  assign BUSY           = (state != ST_IDLE);
  assign ACK            = BUSY ? ack_val : 1'bz;
  assign D              = d_oe ? rd_lane : {DATA_W{1'bz}};
  assign MOD_WRITE_DATA = wr_line;

endmodule
`default_nettype wire
